// File: rtl/fc_layer_par.sv
// Fully-connected layer y = act(W*x + b) with run-time loadable W/b over the input stream.
// P output rows are accumulated in parallel per pass; results are ReLU'd (optional) then saturated.
module fc_layer_par #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int T     = 16,
  parameter int P     = 2,
  parameter int RELU  = 1,
  parameter int ACC_W = 2*T + $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  input  logic                s_load,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic                busy
);

  localparam int PASSES = M / P;
  localparam int AW = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(N + 2);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = $clog2(P + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-T+1){1'b1}}, {(T-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, LOAD_X, MAC, DRAIN} state_t;
  state_t state, state_nx;

  logic signed [T-1:0]     w_mem [M*N];
  logic signed [T-1:0]     b_mem [M];
  logic signed [T-1:0]     x_mem [N];

  logic [AW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [PW-1:0]           pass;
  logic [DW-1:0]           ld_cnt;
  logic                    rd_v;

  logic signed [T-1:0]     w_q [P];
  logic signed [T-1:0]     x_q;
  logic signed [ACC_W-1:0] acc [P];
  logic signed [2*T-1:0]   prod [P];
  logic [AW-1:0]           w_raddr [P];
  logic [BW-1:0]           b_raddr [P];
  logic signed [T-1:0]     drain_word;

  logic s_hs, m_hs, last_out, issue, mac_rd;

  function automatic logic signed [T-1:0] finish(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] v;
    v = (RELU != 0 && a[ACC_W-1]) ? '0 : a;
    if (v > SAT_MAX)      return SAT_MAX[T-1:0];
    else if (v < SAT_MIN) return SAT_MIN[T-1:0];
    else                  return v[T-1:0];
  endfunction

  assign s_hs     = s_valid && s_ready;
  assign m_hs     = m_valid && m_ready;
  assign last_out = m_hs && (ld_cnt == DW'(P));
  assign issue    = (state == DRAIN) && (!m_valid || m_ready) && (ld_cnt < DW'(P));
  assign mac_rd   = (state == MAC) && (cnt < CW'(N));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (s_hs) state_nx = s_load ? ((M*N == 1) ? LOAD_B : LOAD_W)
                                          : ((N == 1) ? MAC : LOAD_X);
      LOAD_W: if (s_hs && idx == AW'(M*N-1)) state_nx = LOAD_B;
      LOAD_B: if (s_hs && idx == AW'(M-1))   state_nx = IDLE;
      LOAD_X: if (s_hs && idx == AW'(N-1))   state_nx = MAC;
      MAC:    if (cnt == CW'(N+1))           state_nx = DRAIN;
      DRAIN:  if (last_out) state_nx = (pass == PW'(PASSES-1)) ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  // Reset gates s_ready so that a handshake coincident with reset never looks accepted.
  always_comb begin
    s_ready = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE, LOAD_W, LOAD_B, LOAD_X: s_ready = reset;
      default:                      s_ready = 1'b0;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < P; k++) begin
      w_raddr[k] = AW'((int'(pass) * P + int'(k)) * N + int'(cnt));
      b_raddr[k] = BW'(int'(pass) * P + int'(k));
      prod[k]    = (2*T)'(w_q[k]) * (2*T)'(x_q);
    end
    drain_word = finish(acc[LW'(ld_cnt)]);
  end

  always_ff @(posedge clk) begin
    if (s_hs) begin
      case (state)
        IDLE:    if (s_load) w_mem[0] <= data_in;
                 else        x_mem[0] <= data_in;
        LOAD_W:  w_mem[idx]     <= data_in;
        LOAD_B:  b_mem[BW'(idx)] <= data_in;
        LOAD_X:  x_mem[XW'(idx)] <= data_in;
        default: ;
      endcase
    end
  end

  // Operands are registered one cycle ahead; rd_v marks when w_q/x_q hold a valid pair.
  always_ff @(posedge clk) begin
    if (mac_rd) begin
      for (int unsigned k = 0; k < P; k++) w_q[k] <= w_mem[w_raddr[k]];
      x_q <= x_mem[XW'(cnt)];
    end
    for (int unsigned k = 0; k < P; k++) begin
      if (state == MAC && cnt == '0) acc[k] <= ACC_W'(b_mem[b_raddr[k]]);
      else if (rd_v)                 acc[k] <= acc[k] + ACC_W'(prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx      <= '0;
      cnt      <= '0;
      pass     <= '0;
      ld_cnt   <= '0;
      rd_v     <= 1'b0;
      m_valid  <= 1'b0;
      data_out <= '0;
    end else begin
      rd_v <= mac_rd;
      case (state)
        IDLE: begin
          cnt    <= '0;
          pass   <= '0;
          ld_cnt <= '0;
          if (s_hs) idx <= AW'(1);
        end
        LOAD_W: if (s_hs) idx <= (idx == AW'(M*N-1)) ? '0 : idx + 1'b1;
        LOAD_B, LOAD_X: if (s_hs) idx <= idx + 1'b1;
        MAC: cnt <= cnt + 1'b1;
        DRAIN: begin
          if (issue) begin
            data_out <= drain_word;
            m_valid  <= 1'b1;
            ld_cnt   <= ld_cnt + 1'b1;
          end else if (m_hs) begin
            m_valid  <= 1'b0;
          end
          if (last_out) begin
            cnt    <= '0;
            ld_cnt <= '0;
            pass   <= pass + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: a ReLU and a linear instance share stimulus; results are checked
// against a plain-arithmetic matrix-vector model.
module tb_fc_layer_par;
  localparam int M = 4;
  localparam int N = 4;
  localparam int T = 16;
  localparam int P = 2;

  logic clk = 1'b0;
  logic reset, s_valid, s_load, m_ready;
  logic signed [T-1:0] data_in;
  logic s_ready_r, m_valid_r, busy_r, s_ready_l, m_valid_l, busy_l;
  logic signed [T-1:0] dout_r, dout_l;

  fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) u_relu (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
    .s_load(s_load), .m_valid(m_valid_r), .m_ready(m_ready), .data_out(dout_r), .busy(busy_r));

  fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) u_lin (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_l), .data_in(data_in),
    .s_load(s_load), .m_valid(m_valid_l), .m_ready(m_ready), .data_out(dout_l), .busy(busy_l));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int w_m [M*N];
  int b_m [M];
  int x_m [N];
  logic signed [T-1:0] q_r [$];
  logic signed [T-1:0] q_l [$];

  always @(negedge clk) begin
    if (reset) begin
      if (m_valid_r && m_ready) q_r.push_back(dout_r);
      if (m_valid_l && m_ready) q_l.push_back(dout_l);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int model(input int row, input bit relu);
    longint a;
    a = b_m[row];
    for (int j = 0; j < N; j++) a += longint'(w_m[row*N + j]) * longint'(x_m[j]);
    if (relu && a < 0) a = 0;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    return int'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int d, input bit load, input bit gaps);
    if (gaps && $urandom_range(2) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(3, 1)) begin
        data_in = T'($urandom);
        tick();
        check("gap_s_ready", {30'd0, s_ready_r, s_ready_l}, 32'd3);
      end
    end
    s_valid = 1'b1;
    s_load  = load;
    data_in = T'(d);
    check("s_ready", {30'd0, s_ready_r, s_ready_l}, 32'd3);
    tick();
    s_valid = 1'b0;
    s_load  = 1'($urandom_range(1));
    data_in = '0;
  endtask

  task automatic load_params(input bit gaps);
    send_word(w_m[0], 1'b1, gaps);
    for (int i = 1; i < M*N; i++) send_word(w_m[i], 1'($urandom_range(1)), gaps);
    for (int i = 0; i < M; i++) send_word(b_m[i], 1'($urandom_range(1)), gaps);
    check("after_load_busy", {30'd0, busy_r, busy_l}, 32'd0);
    check("after_load_mvalid", {30'd0, m_valid_r, m_valid_l}, 32'd0);
  endtask

  task automatic send_x(input bit gaps);
    q_r.delete();
    q_l.delete();
    send_word(x_m[0], 1'b0, gaps);
    for (int i = 1; i < N; i++) send_word(x_m[i], 1'($urandom_range(1)), gaps);
  endtask

  task automatic collect_check(input string tag, input bit rand_ready);
    int budget;
    logic signed [T-1:0] got;
    budget = 0;
    while ((q_r.size() < M || q_l.size() < M) && budget < 300) begin
      m_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      tick();
      budget++;
    end
    m_ready = 1'b1;
    repeat (4) tick();
    check($sformatf("%s_count_relu", tag), q_r.size(), M);
    check($sformatf("%s_count_lin", tag), q_l.size(), M);
    for (int i = 0; i < M; i++) begin
      got = (i < q_r.size()) ? q_r[i] : 'x;
      check($sformatf("%s_relu_row%0d", tag, i), got, model(i, 1'b1));
      got = (i < q_l.size()) ? q_l[i] : 'x;
      check($sformatf("%s_lin_row%0d", tag, i), got, model(i, 1'b0));
    end
    check($sformatf("%s_idle_busy", tag), {30'd0, busy_r, busy_l}, 32'd0);
  endtask

  task automatic load_identity();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) w_m[i*N + j] = (i == j) ? 1 : 0;
    for (int i = 0; i < M; i++) b_m[i] = i + 1;
    load_params(1'b0);
  endtask

  initial begin
    int lat;
    bit mac_ok;
    int w;

    reset = 1'b0; s_valid = 1'b0; s_load = 1'b0; m_ready = 1'b1; data_in = '0;
    repeat (3) tick();
    check("rst_s_ready", {30'd0, s_ready_r, s_ready_l}, 32'd0);
    check("rst_m_valid", {30'd0, m_valid_r, m_valid_l}, 32'd0);
    check("rst_busy", {30'd0, busy_r, busy_l}, 32'd0);
    check("rst_dout_relu", dout_r, 32'd0);
    check("rst_dout_lin", dout_l, 32'd0);
    reset = 1'b1;
    tick();
    check("idle_s_ready", {30'd0, s_ready_r, s_ready_l}, 32'd3);

    // Identity weights, latency and MAC-phase handshake behaviour.
    load_identity();
    x_m = '{10, -20, 30, -40};
    send_x(1'b0);
    lat = 0;
    mac_ok = 1'b1;
    while (!m_valid_r && lat < 40) begin
      if (s_ready_r || s_ready_l || !busy_r || !busy_l) mac_ok = 1'b0;
      tick();
      lat++;
    end
    check("latency", lat, N + 3);
    check("mac_sready0_busy1", {31'd0, mac_ok}, 32'd1);
    check("ident_row0_const", dout_r, 32'd11);
    collect_check("ident", 1'b0);

    // Weights persist; first output held under back-pressure.
    x_m = '{1, 1, 1, 1};
    m_ready = 1'b0;
    send_x(1'b0);
    w = 0;
    while (!(m_valid_r && m_valid_l) && w < 40) begin
      tick();
      w++;
    end
    check("hold_reached", {30'd0, m_valid_r, m_valid_l}, 32'd3);
    repeat (5) begin
      check("hold_valid", {30'd0, m_valid_r, m_valid_l}, 32'd3);
      check("hold_data_relu", dout_r, model(0, 1'b1));
      check("hold_data_lin", dout_l, 32'd2);
      tick();
    end
    collect_check("persist", 1'b1);

    // Random weights with stream gaps, then the same x gap-free.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < M*N; i++)
        w_m[i] = (t % 2 == 0) ? int'($urandom_range(600)) - 300 : int'($urandom_range(65535)) - 32768;
      for (int i = 0; i < M; i++)
        b_m[i] = (t % 2 == 0) ? int'($urandom_range(2000)) - 1000 : int'($urandom_range(65535)) - 32768;
      for (int i = 0; i < N; i++)
        x_m[i] = (t % 2 == 0) ? int'($urandom_range(600)) - 300 : int'($urandom_range(65535)) - 32768;
      load_params(1'b1);
      send_x(1'b1);
      collect_check($sformatf("rand%0d_gaps", t), 1'b1);
      send_x(1'b0);
      collect_check($sformatf("rand%0d_nogap", t), 1'b1);
    end

    // Saturation at both rails.
    for (int i = 0; i < M*N; i++) w_m[i] = 32767;
    for (int i = 0; i < M; i++) b_m[i] = 0;
    for (int i = 0; i < N; i++) x_m[i] = 32767;
    load_params(1'b0);
    send_x(1'b0);
    collect_check("sat_pos", 1'b0);
    check("sat_pos_const", q_l[0], 32'd32767);
    for (int i = 0; i < M*N; i++) w_m[i] = -32768;
    load_params(1'b0);
    send_x(1'b0);
    collect_check("sat_neg", 1'b1);
    check("sat_neg_const", q_l[M-1], 32'hFFFF8000);

    // Reset pulse in the middle of MAC; stored weights survive.
    load_identity();
    x_m = '{7, -3, 100, -9};
    send_x(1'b0);
    repeat (3) tick();
    check("midmac_busy", {30'd0, busy_r, busy_l}, 32'd3);
    reset = 1'b0;
    tick();
    check("midrst_m_valid", {30'd0, m_valid_r, m_valid_l}, 32'd0);
    check("midrst_busy", {30'd0, busy_r, busy_l}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_idle_ready", {30'd0, s_ready_r, s_ready_l}, 32'd3);
    x_m = '{-5, 12, 0, 40};
    send_x(1'b1);
    collect_check("post_reset", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_layer_par.md
Name: fc_layer_par

Overview:
- Parametrised fully-connected layer: y = act(W·x + b), with W an M×N matrix, b an M-vector, and x an N-vector.
- Successor to the fixed 4×4 ROM-based layers: W and b are run-time loadable over the input stream, P output rows are computed in parallel, and the accumulator is wide.
- Output is saturated to T bits; ReLU is optional.
- Sits between valid/ready stream stages in the layer chain.

Parameters:
- M, 8, number of outputs (rows); must be a multiple of P.
- N, 8, number of inputs (columns).
- T, 16, signed data width of all stream words.
- P, 2, parallel MAC lanes, i.e. rows computed per pass.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed results.
- ACC_W, 2*T+$clog2(N)+1, accumulator width.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-low reset; the block is reset in any cycle where reset==0 at the clk edge.
- s_valid, input, 1: input word valid.
- s_ready, output, 1: block accepts a word this cycle.
- data_in, input, T: signed input word.
- s_load, input, 1: packet type, sampled only on the first accepted word of a packet.
- m_valid, output, 1: output word valid.
- m_ready, input, 1: downstream accepts.
- data_out, output, T: signed result.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Handshake: a transfer occurs when valid&&ready on the same edge.
  - s_ready is combinational from state only; it does not depend on s_valid.
  - While m_valid&&!m_ready, data_out and m_valid hold stable.
- Reset (reset==0): state=IDLE; s_ready=0, m_valid=0, data_out=0, busy=0; all counters cleared.
  - W/b/x storage is NOT cleared. Weights persist across reset and across packets; contents are undefined until the first load packet.
- FSM states:
  - IDLE: s_ready=1. On first handshake: if s_load=1, write the word as W[0][0] and go to LOAD_W; else write it as x[0] and go to LOAD_X (N=1: straight to MAC).
  - LOAD_W: s_ready=1. Accepts the remaining M*N-1 words, row-major (W[i][j] at address i*N+j), then goes to LOAD_B.
  - LOAD_B: s_ready=1. Accepts M bias words b[0..M-1], then goes to IDLE. No output is produced for a load packet.
  - LOAD_X: s_ready=1. Accepts the remaining x words, then goes to MAC with pass=0.
  - MAC: s_ready=0.
    - Runs N address cycles; lane k accumulates row pass*P+k.
    - Accumulators are initialised to sign-extended b[row] in the first MAC cycle.
    - Products are full 2T-bit signed and are sign-extended into ACC_W.
    - Memory read latency is 1 cycle; one finishing cycle follows, then go to DRAIN.
  - DRAIN: emits the P lane results in lane order (rows pass*P .. pass*P+P-1), one per m_ready handshake.
    - After the last handshake: if pass<M/P-1, increment pass and return to MAC; else go to IDLE.
- Result per lane: ReLU applied first (if RELU=1), then saturate to [-2^(T-1), 2^(T-1)-1].
- Output order: rows 0..M-1, strictly ascending.
- Latency: m_valid for row pass*P rises exactly N+3 cycles after MAC is entered.
  - Subsequent words in a pass are available on the cycle after each handshake, so there are no bubbles when m_ready=1.
- Input acceptance: a new packet is accepted only in IDLE. There is no overlap of loading with computing.
- Simultaneous events: reset==0 overrides any handshake in the same cycle, and that handshake is dropped.
- Reset mid-operation (any state): next state IDLE. A partial W/b load leaves the already-written entries modified.

Test Plan:
- M=4,N=4,P=2,RELU=1, load W=identity, b={1,2,3,4}, then x={10,-20,30,-40} -> outputs 11, 0, 33, 0 in order; m_valid rises N+3=7 cycles after MAC entry for row 0.
- Same W/b, RELU=0, x={10,-20,30,-40} -> 11, -18, 33, -36; second x packet {1,1,1,1} without reload -> 2, 3, 4, 5 (weights persist).
- T=16, W all 32767, b all 0, x all 32767, RELU=0 -> every output 32767; W all -32768, x all 32767 -> every output -32768 (saturation; ACC_W must not overflow).
- Hold m_ready=0 for 5 cycles on the first output -> data_out/m_valid stable for 5 cycles, no word lost or duplicated; random m_ready thereafter -> exactly M outputs in row order.
- Random s_valid gaps during LOAD_W/LOAD_X -> s_ready stays 1, results are identical to the gap-free case; s_ready=0 throughout MAC/DRAIN.
- reset=0 asserted for 1 cycle mid-MAC -> next cycle: IDLE, m_valid=0, busy=0; a fresh x packet then produces correct results using the previously loaded W/b.
